// File: rtl/hdmi_pixel_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_fetch_pkg
// Brief    : Shared types and constants for the HDMI pixel fetch block.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_fetch_pkg;

    localparam int          c_RGB565_W  = 16;
    localparam int          c_RGB888_W  = 24;
    localparam logic [23:0] c_UNDER_RGB = 24'h000000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ACTIVE  = 3'd2,
        DRAIN   = 3'd3,
        FLUSH   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hdmi_pixel_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pixel_fetch_if
// Brief    : Read-side port bundle of the async frame FIFO (pixel clock).
// Revision : 1.0 - initial release
// ============================================================================
interface hdmi_pixel_fetch_if
    import hdmi_fetch_pkg::*;
#(
    parameter int LVL_W = 13
);
    logic                  fifo_rd_en;
    logic [c_RGB565_W-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic [LVL_W-1:0]      fifo_rd_water_level;
    logic                  fifo_rst;

    modport master (
        output fifo_rd_en,
        output fifo_rst,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        input  fifo_rd_water_level
    );

    modport slave (
        input  fifo_rd_en,
        input  fifo_rst,
        output fifo_rd_data,
        output fifo_rd_empty,
        output fifo_rd_water_level
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_pixel_fetch_rgb565_to_888.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_to_888
// Brief    : Combinational RGB565 -> RGB888 expansion by MSB replication.
// Revision : 1.0 - initial release
// ============================================================================
module rgb565_to_888
    import hdmi_fetch_pkg::*;
(
    input  wire logic [c_RGB565_W-1:0] i_rgb565,
    output logic      [c_RGB888_W-1:0] o_rgb888
);
    assign o_rgb888 = {i_rgb565[15:11], i_rgb565[15:13],
                       i_rgb565[10:5],  i_rgb565[10:9],
                       i_rgb565[4:0],   i_rgb565[4:2]};
endmodule
`default_nettype wire

// File: rtl/hdmi_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pixel_fetch
// Brief    : Pops RGB565 pixels from the frame FIFO in step with de/hs/vs,
//            expands to RGB888, and recovers from underflow/misalignment.
//            Optional macro HDMI_PIXEL_FETCH_UFLOW_CNT_EN adds an underflow
//            counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_pixel_fetch
    import hdmi_fetch_pkg::*;
#(
    parameter int          H_ACT       = 1280,
    parameter int          V_ACT       = 720,
    parameter int          LVL_W       = 13,
    parameter int          PREFILL_LVL = 1024,
    parameter int          FLUSH_CYC   = 8,
    parameter int          VS_POL      = 1,
    parameter logic [23:0] UNDER_RGB   = c_UNDER_RGB
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  vs_in,
    input  wire logic                  hs_in,
    input  wire logic                  de_in,
    hdmi_pixel_fetch_if.master         fifo,
    output logic                       frame_req,
    output logic                       vs_out,
    output logic                       hs_out,
    output logic                       de_out,
    output logic [c_RGB888_W-1:0]      rgb_out,
    output logic                       underflow,
    output logic                       frame_err
`ifdef HDMI_PIXEL_FETCH_UFLOW_CNT_EN
    ,
    input  wire logic                  cnt_clr,
    output logic [15:0]                underflow_cnt
`endif
);
    localparam int          c_FRAME_PIX  = H_ACT * V_ACT;
    localparam int          c_CNT_W      = $clog2(c_FRAME_PIX + 1);
    localparam int          c_FC_W       = $clog2(FLUSH_CYC + 1);
    localparam logic        c_VS_ACT     = (VS_POL != 0);
    localparam logic [c_FC_W-1:0] c_FLUSH_LAST = c_FC_W'(FLUSH_CYC - 1);

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_pix_cnt;
    logic [c_FC_W-1:0]     r_flush_cnt;
    logic                  r_fs_pend;
    logic                  r_frame_req;
    logic                  r_frame_err;
    logic                  r_fifo_rst;

    logic                  r_de_p1, r_hs_p1, r_vs_p1, r_pop_p1, r_uf_p1;
    logic                  r_de_p2, r_hs_p2, r_vs_p2, r_uf_p2;
    logic [c_RGB888_W-1:0] r_rgb;

    logic                  w_fs;
    logic                  w_pop;
    logic                  w_uf;
    logic                  w_lvl_ok;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_last;
    logic [c_RGB888_W-1:0] w_rgb888;

    // The vs pipe doubles as the frame-start edge detector.
    assign w_fs      = (r_vs_p1 == c_VS_ACT) && (r_vs_p2 != c_VS_ACT);
    assign w_pop     = de_in && (r_state == ACTIVE) && !fifo.fifo_rd_empty;
    assign w_uf      = de_in && (r_state == ACTIVE) &&  fifo.fifo_rd_empty;
    assign w_lvl_ok  = (fifo.fifo_rd_water_level >= LVL_W'(PREFILL_LVL));
    assign w_cnt_inc = r_pix_cnt + c_CNT_W'(1);
    assign w_last    = (w_cnt_inc == c_CNT_W'(c_FRAME_PIX));

    assign fifo.fifo_rd_en = w_pop;
    assign fifo.fifo_rst   = r_fifo_rst;
    assign frame_req       = r_frame_req;
    assign frame_err       = r_frame_err;
    assign vs_out          = r_vs_p2;
    assign hs_out          = r_hs_p2;
    assign de_out          = r_de_p2;
    assign rgb_out         = r_rgb;
    assign underflow       = r_uf_p2;

    rgb565_to_888 u_expand (
        .i_rgb565 (fifo.fifo_rd_data),
        .o_rgb888 (w_rgb888)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_p1  <= 1'b0;
            r_hs_p1  <= 1'b0;
            r_vs_p1  <= 1'b0;
            r_pop_p1 <= 1'b0;
            r_uf_p1  <= 1'b0;
            r_de_p2  <= 1'b0;
            r_hs_p2  <= 1'b0;
            r_vs_p2  <= 1'b0;
            r_uf_p2  <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_de_p1  <= de_in;
            r_hs_p1  <= hs_in;
            r_vs_p1  <= vs_in;
            r_pop_p1 <= w_pop;
            r_uf_p1  <= w_uf;
            r_de_p2  <= r_de_p1;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
            r_uf_p2  <= r_uf_p1;
            if (r_pop_p1) begin
                r_rgb <= w_rgb888;
            end else if (r_de_p1) begin
                r_rgb <= UNDER_RGB;
            end else begin
                r_rgb <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pix_cnt   <= '0;
            r_flush_cnt <= '0;
            r_fs_pend   <= 1'b0;
            r_frame_req <= 1'b0;
            r_frame_err <= 1'b0;
            r_fifo_rst  <= 1'b0;
        end else begin
            r_frame_req <= 1'b0;
            r_frame_err <= 1'b0;
            r_fs_pend   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fs) begin
                        r_frame_req <= 1'b1;
                        r_pix_cnt   <= '0;
                        r_state     <= PREFILL;
                    end
                end
                PREFILL: begin
                    // Active video before prefill completes means the frame start was missed.
                    if (w_fs || de_in) begin
                        r_frame_err <= 1'b1;
                        r_fifo_rst  <= 1'b1;
                        r_flush_cnt <= '0;
                        r_state     <= FLUSH;
                    end else if (w_lvl_ok) begin
                        r_pix_cnt <= '0;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (de_in) begin
                        r_pix_cnt <= w_cnt_inc;
                    end
                    if (de_in && w_last) begin
                        r_fs_pend <= w_fs;
                        r_state   <= DRAIN;
                    end else if (w_fs) begin
                        r_frame_err <= 1'b1;
                        r_fifo_rst  <= 1'b1;
                        r_flush_cnt <= '0;
                        r_state     <= FLUSH;
                    end
                end
                DRAIN: begin
                    if (w_fs || r_fs_pend) begin
                        if (fifo.fifo_rd_empty) begin
                            r_frame_req <= 1'b1;
                            r_pix_cnt   <= '0;
                            r_state     <= PREFILL;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_fifo_rst  <= 1'b1;
                            r_flush_cnt <= '0;
                            r_state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_fifo_rst  <= 1'b0;
                        r_frame_req <= 1'b1;
                        r_pix_cnt   <= '0;
                        r_state     <= PREFILL;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_FC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef HDMI_PIXEL_FETCH_UFLOW_CNT_EN
    logic [15:0] r_uf_cnt;

    assign underflow_cnt = r_uf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uf_cnt <= '0;
        end else if (cnt_clr) begin
            r_uf_cnt <= '0;
        end else if (r_uf_p2 && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_pixel_fetch
// Brief    : Directed table-driven bench for hdmi_pixel_fetch (4x2 frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_pixel_fetch;
    import hdmi_fetch_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        de_in = 1'b0;
    logic        frame_req, vs_out, hs_out, de_out, underflow, frame_err;
    logic [23:0] rgb_out;
`ifdef HDMI_PIXEL_FETCH_UFLOW_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] underflow_cnt;
`endif

    always #5 clk = ~clk;

    hdmi_pixel_fetch_if #(.LVL_W(13)) ifc ();

    hdmi_pixel_fetch #(
        .H_ACT(4), .V_ACT(2), .LVL_W(13), .PREFILL_LVL(4),
        .FLUSH_CYC(8), .VS_POL(1), .UNDER_RGB(24'h000000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .fifo      (ifc),
        .frame_req (frame_req),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .rgb_out   (rgb_out),
        .underflow (underflow),
        .frame_err (frame_err)
`ifdef HDMI_PIXEL_FETCH_UFLOW_CNT_EN
        ,
        .cnt_clr       (cnt_clr),
        .underflow_cnt (underflow_cnt)
`endif
    );

    // FIFO read-side model: 1-cycle read latency, flush discards contents.
    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;

    assign ifc.fifo_rd_empty       = (wr_ptr == rd_ptr) || force_empty;
    assign ifc.fifo_rd_water_level = 13'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (ifc.fifo_rst) begin
            rd_ptr <= wr_ptr;
        end else if (ifc.fifo_rd_en) begin
            ifc.fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    int n_req = 0;
    int n_err = 0;
    int n_uf  = 0;
    always @(negedge clk) begin
        if (frame_req) n_req++;
        if (frame_err) n_err++;
        if (underflow) n_uf++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        fe;
        logic [23:0] rgb;
        logic        uf;
    } vec_t;

    vec_t tbl [0:15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_std();
        push(16'hF800); push(16'h07E0); push(16'h001F); push(16'h0841);
        push(16'hFFFF); push(16'h0000); push(16'h8410); push(16'h7BEF);
    endtask

    // Checks vector i-2 while applying vector i: outputs trail inputs by 2 edges.
    task automatic run_table(input int first, input int n);
        vec_t v;
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                v = tbl[first + i - 2];
                chk($sformatf("rgb[%0d]", first + i - 2), 32'(rgb_out), 32'(v.rgb));
                chk($sformatf("de_out[%0d]", first + i - 2), 32'(de_out), 32'(v.de));
                chk($sformatf("hs_out[%0d]", first + i - 2), 32'(hs_out), 32'(v.hs));
                chk($sformatf("uflow[%0d]", first + i - 2), 32'(underflow), 32'(v.uf));
            end
            if (i < n) begin
                v           = tbl[first + i];
                de_in       = v.de;
                hs_in       = v.hs;
                force_empty = v.fe;
            end else begin
                de_in       = 1'b0;
                hs_in       = 1'b0;
                force_empty = 1'b0;
            end
            tick();
        end
    endtask

    task automatic wait_flush(input string nm);
        int n_rst;
        bit seen;
        n_rst = 0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.fifo_rst) n_rst++;
            if (frame_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, " fifo_rst cycles"}, 32'(n_rst), 32'd8);
        chk({nm, " frame_req after flush"}, 32'(seen), 32'd1);
        chk({nm, " state after flush"}, 32'(dut.r_state), 32'(PREFILL));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_req, b_err, b_uf, b_rd;

        tbl[0]  = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'hFF0000, uf:1'b0};
        tbl[1]  = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h00FF00, uf:1'b0};
        tbl[2]  = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h0000FF, uf:1'b0};
        tbl[3]  = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'h080808, uf:1'b0};
        tbl[4]  = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'hFFFFFF, uf:1'b0};
        tbl[5]  = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h000000, uf:1'b0};
        tbl[6]  = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'h848284, uf:1'b0};
        tbl[7]  = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h7B7D7B, uf:1'b0};
        tbl[8]  = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'hFF0000, uf:1'b0};
        tbl[9]  = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h00FF00, uf:1'b0};
        tbl[10] = '{de:1'b1, hs:1'b0, fe:1'b1, rgb:24'h000000, uf:1'b1};
        tbl[11] = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h0000FF, uf:1'b0};
        tbl[12] = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h080808, uf:1'b0};
        tbl[13] = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'hFFFFFF, uf:1'b0};
        tbl[14] = '{de:1'b1, hs:1'b0, fe:1'b0, rgb:24'h000000, uf:1'b0};
        tbl[15] = '{de:1'b1, hs:1'b1, fe:1'b0, rgb:24'h848284, uf:1'b0};

        // Reset state
        tick();
        chk("reset rgb_out", 32'(rgb_out), 32'd0);
        chk("reset de_out", 32'(de_out), 32'd0);
        chk("reset frame_req", 32'(frame_req), 32'd0);
        chk("reset fifo_rst", 32'(ifc.fifo_rst), 32'd0);
        chk("reset state", 32'(dut.r_state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        tick();

        // Normal frame
        push_std();
        b_req = n_req; b_err = n_err; b_uf = n_uf;
        vs_pulse();
        tick();
        chk("normal frame_req", 32'(frame_req), 32'd1);
        chk("normal state prefill", 32'(dut.r_state), 32'(PREFILL));
        tick();
        chk("normal state active", 32'(dut.r_state), 32'(ACTIVE));
        run_table(0, 8);
        chk("normal state drain", 32'(dut.r_state), 32'(DRAIN));
        chk("normal req count", 32'(n_req - b_req), 32'd1);
        chk("normal err count", 32'(n_err - b_err), 32'd0);
        chk("normal uflow count", 32'(n_uf - b_uf), 32'd0);

        // Prefill gating (fs in DRAIN with empty FIFO restarts cleanly)
        b_err = n_err;
        vs_pulse();
        tick();
        chk("prefill frame_req", 32'(frame_req), 32'd1);
        push(16'hF800); push(16'h07E0); push(16'h001F);
        b_rd = rd_ptr;
        repeat (3) tick();
        chk("prefill lvl3 state", 32'(dut.r_state), 32'(PREFILL));
        chk("prefill lvl3 no pops", 32'(rd_ptr), 32'(b_rd));
        chk("prefill rgb idle", 32'(rgb_out), 32'd0);
        push(16'h0841);
        tick();
        chk("prefill lvl4 active", 32'(dut.r_state), 32'(ACTIVE));
        chk("prefill no err", 32'(n_err - b_err), 32'd0);

        // Underflow on 3rd pixel, one stale word left
        push(16'hFFFF); push(16'h0000); push(16'h8410); push(16'h7BEF);
        b_uf = n_uf;
        run_table(8, 8);
        chk("uflow state drain", 32'(dut.r_state), 32'(DRAIN));
        chk("uflow pulse count", 32'(n_uf - b_uf), 32'd1);
        chk("uflow stale words", 32'(wr_ptr - rd_ptr), 32'd1);
        vs_pulse();
        tick();
        chk("stale frame_err", 32'(frame_err), 32'd1);
        chk("stale fifo_rst", 32'(ifc.fifo_rst), 32'd1);
        chk("stale state flush", 32'(dut.r_state), 32'(FLUSH));
        wait_flush("stale");
        chk("stale fifo flushed", 32'(wr_ptr - rd_ptr), 32'd0);

        // Short frame: fs after 5 of 8 pixels
        push_std();
        tick();
        chk("short state active", 32'(dut.r_state), 32'(ACTIVE));
        run_table(0, 5);
        b_err = n_err;
        vs_pulse();
        tick();
        chk("short frame_err", 32'(frame_err), 32'd1);
        chk("short state flush", 32'(dut.r_state), 32'(FLUSH));
        wait_flush("short");
        chk("short err count", 32'(n_err - b_err), 32'd1);

        // Reset mid-ACTIVE
        push(16'hF800); push(16'h07E0); push(16'h001F); push(16'h0841);
        tick();
        chk("rst pre state active", 32'(dut.r_state), 32'(ACTIVE));
        de_in = 1'b1;
        tick();
        tick();
        chk("rst pre rgb", 32'(rgb_out), 32'hFF0000);
        rst_n = 1'b0;
        #1;
        chk("rst rgb_out", 32'(rgb_out), 32'd0);
        chk("rst de_out", 32'(de_out), 32'd0);
        chk("rst rd_en", 32'(ifc.fifo_rd_en), 32'd0);
        chk("rst state", 32'(dut.r_state), 32'(IDLE));
        de_in = 1'b0;
        tick();
        rst_n = 1'b1;
        b_req = n_req;
        repeat (5) tick();
        chk("rst no frame_req", 32'(n_req - b_req), 32'd0);
        chk("rst stays idle", 32'(dut.r_state), 32'(IDLE));
        vs_pulse();
        tick();
        chk("rst frame_req on fs", 32'(frame_req), 32'd1);

`ifdef HDMI_PIXEL_FETCH_UFLOW_CNT_EN
        chk("ucnt after reset", 32'(underflow_cnt), 32'd0);
        push(16'h0000); push(16'h0000);
        tick();
        chk("ucnt state active", 32'(dut.r_state), 32'(ACTIVE));
        de_in = 1'b1;
        force_empty = 1'b1;
        repeat (3) tick();
        de_in = 1'b0;
        force_empty = 1'b0;
        repeat (4) tick();
        chk("ucnt three", 32'(underflow_cnt), 32'd3);
        de_in = 1'b1;
        force_empty = 1'b1;
        tick();
        de_in = 1'b0;
        force_empty = 1'b0;
        tick();
        chk("ucnt clr pulse", 32'(underflow), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("ucnt clr wins", 32'(underflow_cnt), 32'd0);
        tick();
        chk("ucnt clr holds", 32'(underflow_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
